// File: rtl/elevator_request_scheduler.sv
// SCAN scheduler ahead of the elevator core: latches call buttons into a pending set,
// retires floors when the door opens there, and registers the next target floor.
module elevator_request_scheduler #(
    parameter int N_FLOORS = 16,
    parameter int FLOOR_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Emergency,
    input  logic [N_FLOORS-1:0] button_press,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                door_status,
    output logic [FLOOR_W-1:0]  floor_request,
    output logic                request_valid,
    output logic [1:0]          sched_dir,
    output logic [N_FLOORS-1:0] pending
);

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    dir_e                dir_q, dir_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]  floor_request_q, floor_request_d;
    logic                request_valid_q, request_valid_d;

    logic [FLOOR_W-1:0]  cf_eff;
    logic [FLOOR_W-1:0]  up_tgt, dn_tgt;
    logic                here, above, below;

    // An out-of-range floor report behaves as the top floor for the sweep.
    always_comb begin
        if (int'(current_floor) >= N_FLOORS) begin
            cf_eff = FLOOR_W'(N_FLOORS - 1);
        end else begin
            cf_eff = current_floor;
        end
    end

    // Nearest pending floor in each direction; scanning with an integer index
    // keeps the pending vector from ever being addressed out of range.
    always_comb begin
        here   = 1'b0;
        above  = 1'b0;
        below  = 1'b0;
        up_tgt = cf_eff;
        dn_tgt = cf_eff;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && i > int'(cf_eff)) begin
                above  = 1'b1;
                up_tgt = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending_q[i] && i < int'(cf_eff)) begin
                below  = 1'b1;
                dn_tgt = FLOOR_W'(i);
            end
            if (pending_q[i] && i == int'(cf_eff)) begin
                here = 1'b1;
            end
        end
    end

    // A press at the floor whose door is open is dropped: the clear term wins.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (!Emergency && !(door_status && int'(current_floor) == i)) begin
                pending_d[i] = pending_q[i] | button_press[i];
            end
        end
    end

    always_comb begin
        dir_d           = dir_q;
        floor_request_d = current_floor;
        request_valid_d = 1'b0;
        case (dir_q)
            DIR_IDLE: dir_d = above ? DIR_UP : (below ? DIR_DOWN : DIR_IDLE);
            DIR_UP:   dir_d = above ? DIR_UP : (below ? DIR_DOWN : DIR_IDLE);
            DIR_DOWN: dir_d = below ? DIR_DOWN : (above ? DIR_UP : DIR_IDLE);
            default:  dir_d = DIR_IDLE;
        endcase
        if (Emergency) begin
            dir_d = DIR_IDLE;
        end else if (here) begin
            floor_request_d = cf_eff;
            request_valid_d = 1'b1;
        end else if (dir_d == DIR_UP) begin
            floor_request_d = up_tgt;
            request_valid_d = 1'b1;
        end else if (dir_d == DIR_DOWN) begin
            floor_request_d = dn_tgt;
            request_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q           <= DIR_IDLE;
            pending_q       <= '0;
            floor_request_q <= '0;
            request_valid_q <= 1'b0;
        end else begin
            dir_q           <= dir_d;
            pending_q       <= pending_d;
            floor_request_q <= floor_request_d;
            request_valid_q <= request_valid_d;
        end
    end

    assign floor_request = floor_request_q;
    assign request_valid = request_valid_q;
    assign sched_dir     = dir_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed scenarios followed by random traffic, all checked against a floor-list
// model of the SCAN policy plus hand-derived constants at the key points.
module tb_elevator_request_scheduler;

    localparam int NF = 16;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          Emergency;
    logic [NF-1:0] button_press;
    logic [FW-1:0] current_floor;
    logic          door_status;
    logic [FW-1:0] floor_request;
    logic          request_valid;
    logic [1:0]    sched_dir;
    logic [NF-1:0] pending;

    int checks   = 0;
    int failures = 0;

    // reference state: set of pending floors, sweep direction (0 idle, 1 up, 2 down), target
    bit m_pend[NF];
    int m_dir;
    int m_fr;
    bit m_valid;

    elevator_request_scheduler #(.N_FLOORS(NF), .FLOOR_W(FW)) dut (
        .clk(clk), .reset(reset), .Emergency(Emergency), .button_press(button_press),
        .current_floor(current_floor), .door_status(door_status),
        .floor_request(floor_request), .request_valid(request_valid),
        .sched_dir(sched_dir), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_dir   = 0;
        m_fr    = 0;
        m_valid = 1'b0;
    endtask

    function automatic logic [NF-1:0] model_pending();
        logic [NF-1:0] v;
        foreach (m_pend[i]) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock edge of the SCAN rules, applied to the inputs present at the edge.
    task automatic model_step();
        int cf = int'(current_floor);
        int nearest_up = -1;
        int nearest_dn = -1;
        if (Emergency) begin
            model_reset();
            m_fr = cf;
            return;
        end
        for (int f = 0; f < NF; f++) begin
            if (m_pend[f] && f > cf && nearest_up < 0) nearest_up = f;
            if (m_pend[f] && f < cf) nearest_dn = f;
        end
        if (m_dir == 2) m_dir = (nearest_dn >= 0) ? 2 : (nearest_up >= 0) ? 1 : 0;
        else            m_dir = (nearest_up >= 0) ? 1 : (nearest_dn >= 0) ? 2 : 0;
        if (m_pend[cf])       begin m_fr = cf;         m_valid = 1'b1; end
        else if (m_dir == 1)  begin m_fr = nearest_up; m_valid = 1'b1; end
        else if (m_dir == 2)  begin m_fr = nearest_dn; m_valid = 1'b1; end
        else                  begin m_fr = cf;         m_valid = 1'b0; end
        for (int f = 0; f < NF; f++) begin
            if (door_status && f == cf) m_pend[f] = 1'b0;
            else if (button_press[f])   m_pend[f] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("pending",       32'(pending),       32'(model_pending()));
        chk("floor_request", 32'(floor_request), 32'(m_fr));
        chk("request_valid", 32'(request_valid), 32'(m_valid));
        chk("sched_dir",     32'(sched_dir),     32'(m_dir));
    endtask

    initial begin
        reset = 1'b1; Emergency = 1'b0; button_press = '0; current_floor = '0; door_status = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_fr",      32'(floor_request), 32'h0);
        chk("reset_valid",   32'(request_valid), 32'h0);
        chk("reset_dir",     32'(sched_dir), 32'h0);

        // basic press from idle at floor 0
        button_press = 16'h0020;
        step();
        button_press = '0;
        chk("press_pending", 32'(pending), 32'h0020);
        chk("press_valid_early", 32'(request_valid), 32'h0);
        step();
        chk("press_fr", 32'(floor_request), 32'd5);
        chk("press_valid", 32'(request_valid), 32'h1);
        chk("press_dir", 32'(sched_dir), 32'h1);
        current_floor = 4'd5; door_status = 1'b1;
        step();
        door_status = 1'b0;
        step();
        chk("press_retired", 32'(pending), 32'h0);

        // SCAN order with floors {1,6,9} from floor 3
        current_floor = 4'd3; button_press = 16'h0242;
        step();
        button_press = '0;
        step();
        chk("scan_first_fr", 32'(floor_request), 32'd6);
        chk("scan_first_dir", 32'(sched_dir), 32'h1);
        current_floor = 4'd6; door_status = 1'b1;
        step();
        door_status = 1'b0;
        step();
        chk("scan_second_fr", 32'(floor_request), 32'd9);
        current_floor = 4'd9; door_status = 1'b1;
        step();
        door_status = 1'b0;
        step();
        chk("scan_rev_dir", 32'(sched_dir), 32'h2);
        chk("scan_rev_fr", 32'(floor_request), 32'd1);
        current_floor = 4'd1; door_status = 1'b1;
        step();
        door_status = 1'b0;
        step();
        chk("scan_done_pending", 32'(pending), 32'h0);
        chk("scan_done_dir", 32'(sched_dir), 32'h0);
        chk("scan_done_valid", 32'(request_valid), 32'h0);

        // press at the open-door floor is dropped; with the door closed it is kept
        current_floor = 4'd4; door_status = 1'b1; button_press = 16'h0010;
        step();
        chk("open_door_drop", 32'(pending[4]), 32'h0);
        door_status = 1'b0;
        step();
        button_press = '0;
        chk("closed_door_keep", 32'(pending[4]), 32'h1);
        step();
        chk("here_fr", 32'(floor_request), 32'd4);
        chk("here_valid", 32'(request_valid), 32'h1);
        chk("here_dir", 32'(sched_dir), 32'h0);
        door_status = 1'b1;
        step();
        door_status = 1'b0;
        step();

        // emergency flush while pressing floor 3
        button_press = 16'h0084;
        step();
        button_press = 16'h0008; Emergency = 1'b1;
        repeat (3) step();
        chk("emg_pending", 32'(pending), 32'h0);
        chk("emg_valid", 32'(request_valid), 32'h0);
        chk("emg_fr", 32'(floor_request), 32'd4);
        Emergency = 1'b0; button_press = '0;
        step();
        button_press = 16'h0008;
        step();
        button_press = '0;
        step();
        chk("post_emg_fr", 32'(floor_request), 32'd3);
        chk("post_emg_valid", 32'(request_valid), 32'h1);
        current_floor = 4'd3; door_status = 1'b1;
        step();
        door_status = 1'b0;
        step();

        // idle tracking across every floor
        for (int f = 0; f < NF; f++) begin
            current_floor = FW'(f);
            step();
            chk("idle_fr", 32'(floor_request), 32'(f));
            chk("idle_valid", 32'(request_valid), 32'h0);
            chk("idle_dir", 32'(sched_dir), 32'h0);
        end

        // asynchronous reset between edges with floors {2,5} pending
        current_floor = 4'd0; button_press = 16'h0024;
        step();
        button_press = '0;
        chk("prereset_pending", 32'(pending), 32'h0024);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_pending", 32'(pending), 32'h0);
        chk("async_fr", 32'(floor_request), 32'h0);
        chk("async_valid", 32'(request_valid), 32'h0);
        chk("async_dir", 32'(sched_dir), 32'h0);
        reset = 1'b0;
        step();
        chk("post_reset_pending", 32'(pending), 32'h0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            button_press  = NF'($urandom & $urandom & $urandom);
            current_floor = FW'($urandom_range(0, NF - 1));
            door_status   = ($urandom_range(0, 2) == 0);
            Emergency     = ($urandom_range(0, 40) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
